// File: rtl/irrigation_monitor.sv
// irrigation_monitor: multi-area humidity monitor with input sync, valve drive and a scanning 7-segment display.
// Define IRRIG_DEBOUNCE_EN to add the per-channel debounce filter; otherwise dry_q follows the synchroniser.
module irrigation_monitor #(
    parameter int NAREAS       = 4,
    parameter int DEBOUNCE_CYC = 3,
    parameter int DWELL_CYC    = 4
) (
    input  logic                        clk_2,
    input  logic                        reset_n,
    input  logic [NAREAS-1:0]           dry,
    input  logic                        enable,
    output logic [NAREAS-1:0]           valve,
    output logic                        alarm,
    output logic [$clog2(NAREAS+1)-1:0] dry_count,
    output logic [7:0]                  seg
);
    localparam int CW = $clog2(NAREAS+1);
    localparam int IW = NAREAS > 1 ? $clog2(NAREAS) : 1;
    localparam int WW = DWELL_CYC > 1 ? $clog2(DWELL_CYC) : 1;

    typedef enum logic {IDLE, SHOW} state_t;

    state_t            state_q, state_d;
    logic [NAREAS-1:0] sync1_q, sync2_q, dry_q, dry_d;
    logic [IW-1:0]     idx_q, idx_d, first_idx, next_idx;
    logic [WW-1:0]     dwell_q, dwell_d;
    logic              has_above;
    logic [6:0]        digit;

`ifdef IRRIG_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_CYC+1);
    logic [DW-1:0] deb_q [NAREAS];
    logic [DW-1:0] deb_d [NAREAS];

    always_comb begin
        dry_d = dry_q;
        for (int i = 0; i < NAREAS; i++) begin
            deb_d[i] = '0;
            if (sync2_q[i] != dry_q[i]) begin
                if (deb_q[i] == DW'(DEBOUNCE_CYC-1))
                    dry_d[i] = sync2_q[i];
                else
                    deb_d[i] = deb_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n)
            deb_q <= '{default: '0};
        else
            deb_q <= deb_d;
    end
`else
    assign dry_d = sync2_q;
`endif

    assign valve = dry_q & {NAREAS{enable}};
    assign alarm = |dry_q;

    always_comb begin
        dry_count = '0;
        for (int i = 0; i < NAREAS; i++)
            dry_count = dry_count + CW'(dry_q[i]);
    end

    // Descending scan so the last hit is the lowest qualifying index.
    always_comb begin
        first_idx = '0;
        next_idx  = '0;
        has_above = 1'b0;
        for (int i = NAREAS-1; i >= 0; i--) begin
            if (dry_q[i])
                first_idx = IW'(i);
            if (dry_q[i] && IW'(i) > idx_q) begin
                next_idx  = IW'(i);
                has_above = 1'b1;
            end
        end
        if (!has_above || idx_q == IW'(NAREAS-1))
            next_idx = first_idx;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dwell_d = dwell_q;
        if (state_q == IDLE) begin
            if (alarm) begin
                state_d = SHOW;
                idx_d   = first_idx;
                dwell_d = '0;
            end
        end else if (!alarm) begin
            state_d = IDLE;
            idx_d   = '0;
            dwell_d = '0;
        end else if (!dry_q[idx_q] || dwell_q == WW'(DWELL_CYC-1)) begin
            idx_d   = next_idx;
            dwell_d = '0;
        end else begin
            dwell_d = dwell_q + 1'b1;
        end
    end

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            dry_q   <= '0;
            state_q <= IDLE;
            idx_q   <= '0;
            dwell_q <= '0;
        end else begin
            sync1_q <= dry;
            sync2_q <= sync1_q;
            dry_q   <= dry_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            dwell_q <= dwell_d;
        end
    end

    always_comb begin
        case (4'(idx_q))
            4'd0:    digit = 7'h3F;
            4'd1:    digit = 7'h06;
            4'd2:    digit = 7'h5B;
            4'd3:    digit = 7'h4F;
            4'd4:    digit = 7'h66;
            4'd5:    digit = 7'h6D;
            4'd6:    digit = 7'h7D;
            4'd7:    digit = 7'h07;
            4'd8:    digit = 7'h7F;
            4'd9:    digit = 7'h6F;
            default: digit = 7'h00;
        endcase
        seg = (state_q == SHOW) ? {dry_count > CW'(1), digit} : 8'h00;
    end
endmodule

// File: tb/tb_irrigation_monitor.sv
// tb_irrigation_monitor: vector table plus scoreboarded scan sequences for irrigation_monitor.
// Expected latencies follow IRRIG_DEBOUNCE_EN so the bench matches either build.
module tb_irrigation_monitor;
    localparam int DWELL = 4;
`ifdef IRRIG_DEBOUNCE_EN
    localparam int LAT = 5;
    localparam bit DEB = 1'b1;
`else
    localparam int LAT = 3;
    localparam bit DEB = 1'b0;
`endif
    localparam logic [7:0] DIG [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                        8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    logic       clk_2   = 1'b0;
    logic       reset_n = 1'b1;
    logic       enable  = 1'b0;
    logic [3:0] dry     = '0;
    logic [9:0] dry10   = '0;
    logic [3:0] valve;
    logic       alarm;
    logic [2:0] dry_count;
    logic [7:0] seg;
    logic [9:0] valve10;
    logic       alarm10;
    logic [3:0] dry_count10;
    logic [7:0] seg10;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    typedef struct packed {
        logic [3:0] dry;
        logic       en;
        logic [3:0] valve;
        logic       alarm;
        logic [2:0] cnt;
        logic [7:0] seg;
    } vec_t;
    vec_t vecs [7];

    always #5 clk_2 = ~clk_2;

    irrigation_monitor #(.NAREAS(4), .DEBOUNCE_CYC(3), .DWELL_CYC(DWELL)) dut (
        .clk_2(clk_2), .reset_n(reset_n), .dry(dry), .enable(enable),
        .valve(valve), .alarm(alarm), .dry_count(dry_count), .seg(seg)
    );

    irrigation_monitor #(.NAREAS(10), .DEBOUNCE_CYC(3), .DWELL_CYC(DWELL)) dut10 (
        .clk_2(clk_2), .reset_n(reset_n), .dry(dry10), .enable(enable),
        .valve(valve10), .alarm(alarm10), .dry_count(dry_count10), .seg(seg10)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_2);
        #1;
    endtask

    // Scan model: each set bit in ascending order for DWELL cycles, dp when more than one area is dry.
    task automatic push_scan(input logic [9:0] m, input int cycles);
        int bits[$];
        int pc;
        for (int i = 0; i < 10; i++)
            if (m[i]) bits.push_back(i);
        pc = bits.size();
        for (int c = 0; c < cycles; c++)
            exp_q.push_back(pc == 0 ? 8'h00 : (DIG[bits[(c / DWELL) % pc]] | (pc > 1 ? 8'h80 : 8'h00)));
    endtask

    initial begin
        vecs[0] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 3'd1, 8'h5B};
        vecs[1] = '{4'b1011, 1'b1, 4'b1011, 1'b1, 3'd3, 8'hBF};
        vecs[2] = '{4'b1011, 1'b0, 4'b0000, 1'b1, 3'd3, 8'hBF};
        vecs[3] = '{4'b1111, 1'b1, 4'b1111, 1'b1, 3'd4, 8'hBF};
        vecs[4] = '{4'b1000, 1'b0, 4'b0000, 1'b1, 3'd1, 8'h4F};
        vecs[5] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 3'd0, 8'h00};
        vecs[6] = '{4'b0110, 1'b1, 4'b0110, 1'b1, 3'd2, 8'h86};

        #2 reset_n = 1'b0;
        step(2);
        check("reset_valve", valve, 0);
        check("reset_alarm", alarm, 0);
        check("reset_count", dry_count, 0);
        check("reset_seg", seg, 8'h00);
        reset_n = 1'b1;
        step(1);

        for (int i = 0; i < 7; i++) begin
            dry = vecs[i].dry;
            enable = vecs[i].en;
            exp_q.push_back(vecs[i].seg);
            step(LAT + 1);
            check("vec_valve", valve, vecs[i].valve);
            check("vec_alarm", alarm, vecs[i].alarm);
            check("vec_count", dry_count, vecs[i].cnt);
            check("vec_seg", seg, exp_q.pop_front());
            dry = '0;
            step(LAT + 3);
        end

        enable = 1'b1;
        dry = 4'b0100;
        step(LAT);
        check("single_alarm", alarm, 1);
        check("single_count", dry_count, 1);
        check("single_idle_seg", seg, 8'h00);
        step(1);
        check("single_valve", valve, 4'b0100);
        push_scan(10'b0100, 10);
        for (int c = 0; c < 10; c++) begin
            check("single_seg", seg, exp_q.pop_front());
            step(1);
        end
        dry = '0;
        step(LAT + 3);

        dry = 4'b1011;
        step(LAT + 1);
        push_scan(10'b1011, 13);
        for (int c = 0; c < 13; c++) begin
            if (c == 5) check("scan_valve_en1", valve, 4'b1011);
            if (c == 6) begin
                enable = 1'b0;
                #1 check("scan_valve_en0", valve, 0);
            end
            check("scan_seg", seg, exp_q.pop_front());
            step(1);
        end
        enable = 1'b1;
        dry = '0;
        step(LAT + 3);

        dry = 4'b0001;
        step(2);
        dry = '0;
        for (int k = 3; k <= 10; k++) begin
            step(1);
            check("glitch_alarm", alarm, (!DEB && (k == 3 || k == 4)) ? 1 : 0);
        end
        step(LAT + 3);
        check("glitch_seg_idle", seg, 8'h00);

        dry = 4'b1001;
        step(LAT + 1);
        check("clr_first", seg, 8'hBF);
        step(DWELL);
        check("clr_area3", seg, 8'hCF);
        dry = 4'b0001;
        step(LAT);
        check("clr_settle", seg, DEB ? 8'h3F : 8'h4F);
        step(1);
        check("clr_next", seg, 8'h3F);
        dry = '0;
        step(LAT + 2);
        check("clr_all_seg", seg, 8'h00);
        check("clr_all_alarm", alarm, 0);

        dry = 4'b1010;
        step(LAT + 3);
        check("pre_reset_seg", seg, 8'h86);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_valve", valve, 0);
        check("midrst_alarm", alarm, 0);
        check("midrst_count", dry_count, 0);
        check("midrst_seg", seg, 8'h00);
        step(1);
        reset_n = 1'b1;
        step(LAT);
        check("rst_release_idle", seg, 8'h00);
        step(1);
        check("rst_release_seg", seg, 8'h86);
        dry = '0;
        step(LAT + 3);

        dry10 = '1;
        step(LAT + 1);
        check("w10_count", dry_count10, 10);
        check("w10_alarm", alarm10, 1);
        push_scan(10'h3FF, 10 * DWELL + 2);
        for (int c = 0; c < 10 * DWELL + 2; c++) begin
            check("w10_seg", seg10, exp_q.pop_front());
            step(1);
        end
        dry10 = '0;
        step(LAT + 3);
        check("w10_idle", seg10, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
